// File: rtl/pid_wb_pkg.sv
// Shared definitions for the PID Wishbone arbiter: FSM state encodings and
// the default watchdog limit.
package pid_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pid_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from i_ptr, wrapping at N-1, as a one-hot vector.
module pid_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win,
    output logic          o_vld
);

    int idx;

    always_comb begin
        o_win = '0;
        o_vld = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(i_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            // Constant-index scan keeps the bit select free of a wide index.
            for (int j = 0; j < N; j++) begin
                if (!o_vld && (j == idx) && i_req[j]) begin
                    o_win[j] = 1'b1;
                    o_vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pid_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the PID controller's slave port among
// N_MST masters. Define PID_ARB_TIMEOUT_EN to build the stalled-grant watchdog.
module pid_wb_arbiter
    import pid_wb_pkg::*;
#(
    parameter int N_MST     = 4,
    parameter int wb_nb     = 32,
    parameter int adr_wb_nb = 16,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_MST-1:0]           i_m_cyc,
    input  logic [N_MST-1:0]           i_m_stb,
    input  logic [N_MST-1:0]           i_m_we,
    input  logic [N_MST*adr_wb_nb-1:0] i_m_adr,
    input  logic [N_MST*wb_nb-1:0]     i_m_data,
    output logic [wb_nb-1:0]           o_m_data,
    output logic [N_MST-1:0]           o_m_ack,
    output logic [N_MST-1:0]           o_m_err,
    output logic                       o_s_cyc,
    output logic                       o_s_stb,
    output logic                       o_s_we,
    output logic [adr_wb_nb-1:0]       o_s_adr,
    output logic [wb_nb-1:0]           o_s_data,
    input  logic [wb_nb-1:0]           i_s_data,
    input  logic                       i_s_ack,
    output logic [N_MST-1:0]           o_gnt
);

    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;

    if ((N_MST < 2) || (N_MST > 8)) begin : g_bad_n_mst
        $error("pid_wb_arbiter: N_MST must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pid_wb_arbiter: TIMEOUT must be at least 1");
    end

    state_t           state_q, state_d;
    logic [N_MST-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    ptr_q, ptr_d, ptr_nxt;
    logic [N_MST-1:0] elig;
    logic [N_MST-1:0] pick_win;
    logic             pick_vld;
    logic             busy;
    logic             cyc_g;
    logic             timeout_hit;

    assign busy = (state_q == ST_BUSY);

    pid_rr_pick #(
        .N  (N_MST),
        .PW (PW)
    ) u_pick (
        .i_req (elig),
        .i_ptr (ptr_q),
        .o_win (pick_win),
        .o_vld (pick_vld)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cyc_g   = 1'b0;
        ptr_nxt = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (gnt_q[k]) begin
                cyc_g   = i_m_cyc[k];
                ptr_nxt = (k == N_MST - 1) ? '0 : PW'(k + 1);
            end
        end
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick_win;
                end
            end
            ST_BUSY: begin
                // Pointer moves past the released master so it ranks last.
                if (!cyc_g || timeout_hit) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_nxt;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_adr  = '0;
        o_s_data = '0;
        o_m_ack  = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (busy && gnt_q[k]) begin
                o_s_cyc    = i_m_cyc[k];
                o_s_stb    = i_m_stb[k];
                o_s_we     = i_m_we[k];
                o_s_adr    = i_m_adr[k*adr_wb_nb +: adr_wb_nb];
                o_s_data   = i_m_data[k*wb_nb +: wb_nb];
                o_m_ack[k] = i_s_ack & i_m_stb[k];
            end
        end
    end

    assign o_m_data = i_s_data;
    assign o_gnt    = gnt_q;

`ifdef PID_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_MST-1:0] inelig_q, inelig_d;
    logic [N_MST-1:0] err_q, err_d;
    logic             stall;

    assign stall       = busy && o_s_stb && !i_s_ack;
    assign timeout_hit = stall && (cnt_q == CW'(TIMEOUT - 1));
    assign elig        = i_m_cyc & ~inelig_q;
    assign o_m_err     = err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q    <= '0;
            inelig_q <= '0;
            err_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            inelig_q <= inelig_d;
            err_q    <= err_d;
        end
    end

    // A timed-out master stays locked out until it drops cyc.
    always_comb begin
        cnt_d    = cnt_q;
        err_d    = '0;
        inelig_d = inelig_q & i_m_cyc;
        if (!busy || (state_d == ST_IDLE) || i_s_ack) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (timeout_hit) begin
            err_d    = gnt_q;
            inelig_d = (inelig_q & i_m_cyc) | gnt_q;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign elig        = i_m_cyc;
    assign o_m_err     = '0;
`endif

endmodule

// File: tb/tb_pid_wb_arbiter.sv
// Directed self-checking bench for pid_wb_arbiter (4 masters, 32-bit data,
// 16-bit address); the watchdog section builds only with PID_ARB_TIMEOUT_EN.
module tb_pid_wb_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 16;
`ifdef PID_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cyc = '0;
    logic [N-1:0]    m_stb = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*W-1:0]  m_data = '0;
    logic [W-1:0]    m_rdata;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [W-1:0]    s_wdata;
    logic [W-1:0]    s_rdata = '0;
    logic            s_ack = 1'b0;
    logic [N-1:0]    gnt;

    int n_pass  = 0;
    int n_total = 0;

    pid_wb_arbiter #(
        .N_MST     (N),
        .wb_nb     (W),
        .adr_wb_nb (AW),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_m_cyc  (m_cyc),
        .i_m_stb  (m_stb),
        .i_m_we   (m_we),
        .i_m_adr  (m_adr),
        .i_m_data (m_data),
        .o_m_data (m_rdata),
        .o_m_ack  (m_ack),
        .o_m_err  (m_err),
        .o_s_cyc  (s_cyc),
        .o_s_stb  (s_stb),
        .o_s_we   (s_we),
        .o_s_adr  (s_adr),
        .o_s_data (s_wdata),
        .i_s_data (s_rdata),
        .i_s_ack  (s_ack),
        .o_gnt    (gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Clock until a grant appears, bounded so a dead arbiter cannot hang the run.
    task automatic wait_gnt(output logic [N-1:0] g);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt != '0) break;
        end
        chk("gnt_arrived", gnt != '0, 1'b1);
        g = gnt;
    endtask

    task automatic set_master(input int k, input logic [AW-1:0] adr, input logic [W-1:0] dat);
        m_adr[k*AW +: AW] = adr;
        m_data[k*W +: W]  = dat;
    endtask

    logic [N-1:0] g;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_ack", m_ack, 4'b0000);
        chk("rst_err", m_err, 4'b0000);

        // Single master write then read-back by m1.
        rst_n = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        set_master(1, 16'h0004, 32'h0000_0005);
        settle();
        chk("idle_s_stb", s_stb, 1'b0);
        tick();
        chk("m1_gnt", gnt, 4'b0010);
        chk("m1_s_stb", s_stb, 1'b1);
        chk("m1_s_we", s_we, 1'b1);
        chk("m1_s_adr", s_adr, 16'h0004);
        chk("m1_s_wdata", s_wdata, 32'h0000_0005);
        s_ack = 1'b1;
        settle();
        chk("m1_wr_ack", m_ack, 4'b0010);
        tick();
        m_we[1] = 1'b0;
        s_rdata = 32'h0000_0005;
        settle();
        chk("m1_rd_ack", m_ack, 4'b0010);
        chk("m1_rd_data", m_rdata, 32'h0000_0005);
        chk("m1_s_we_rd", s_we, 1'b0);
        s_ack = 1'b0;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        chk("m1_release", gnt, 4'b0000);

        // Reset with m1 granted mid-write: no ack even with slave ack high.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        set_master(1, 16'h0008, 32'h0000_0007);
        wait_gnt(g);
        chk("m1_regnt", g, 4'b0010);
        s_ack = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("midrst_gnt", gnt, 4'b0000);
        chk("midrst_s_cyc", s_cyc, 1'b0);
        chk("midrst_ack", m_ack, 4'b0000);
        rst_n = 1'b1;
        s_ack = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;

        // Contention m0 vs m2 after reset: ptr is 0, so m0 first.
        m_cyc = 4'b0101; m_stb = 4'b0101;
        wait_gnt(g);
        chk("cont_first", g, 4'b0001);
        tick();
        chk("cont_hold", gnt, 4'b0001);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        chk("cont_idle_gap", gnt, 4'b0000);
        tick();
        chk("cont_second", gnt, 4'b0100);
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        tick();
        chk("cont_release", gnt, 4'b0000);
        // ptr should now be 3: m3 beats m0.
        m_cyc = 4'b1001; m_stb = 4'b1001;
        wait_gnt(g);
        chk("ptr_is_3", g, 4'b1000);
        m_cyc = '0; m_stb = '0;
        tick();
        tick();

        // Fairness: all masters request; each drops cyc for one edge when served.
        m_cyc = 4'b1111; m_stb = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            wait_gnt(g);
            chk($sformatf("fair_%0d", n), g, 4'b0001 << (n % 4));
            m_cyc = m_cyc & ~g;
            tick();
            chk($sformatf("fair_rel_%0d", n), gnt, 4'b0000);
            m_cyc = 4'b1111;
        end
        m_cyc = '0; m_stb = '0;
        tick();

        // Block transfer by m3 while m0 waits.
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_we[3] = 1'b1;
        wait_gnt(g);
        chk("blk_gnt", g, 4'b1000);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_master(3, 16'(i * 4), 32'h100 + 32'(i));
            s_ack = 1'b1;
            settle();
            chk($sformatf("blk_ack_%0d", i), m_ack, 4'b1000);
            chk($sformatf("blk_adr_%0d", i), s_adr, 16'(i * 4));
            chk($sformatf("blk_dat_%0d", i), s_wdata, 32'h100 + 32'(i));
            chk($sformatf("blk_hold_%0d", i), gnt, 4'b1000);
            tick();
        end
        s_ack = 1'b0;
        m_cyc[3] = 1'b0; m_stb[3] = 1'b0; m_we[3] = 1'b0;
        tick();
        chk("blk_release", gnt, 4'b0000);
        tick();
        chk("blk_next_m0", gnt, 4'b0001);
        chk("err_none", m_err, 4'b0000);
        m_cyc = '0; m_stb = '0;
        tick();

`ifdef PID_ARB_TIMEOUT_EN
        // Watchdog: m0 stalls with ack low; m1 waits behind it.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        wait_gnt(g);
        chk("wd_gnt_m0", g, 4'b0001);
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        repeat (TO - 1) tick();
        chk("wd_no_err_yet", m_err, 4'b0000);
        chk("wd_still_m0", gnt, 4'b0001);
        tick();
        chk("wd_err_pulse", m_err, 4'b0001);
        chk("wd_forced_idle", gnt, 4'b0000);
        tick();
        chk("wd_err_clear", m_err, 4'b0000);
        chk("wd_m1_next", gnt, 4'b0010);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        tick();
        chk("wd_m0_locked", gnt, 4'b0000);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        chk("wd_m0_unlocked", gnt, 4'b0001);
        m_cyc = '0; m_stb = '0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
